// File: rtl/wb_stage_pipelined_pkg.sv
// Shared types for the registered write-back stage: result-source select,
// load funct3 encodings and the stage FSM states.
package riscv_wb_pkg;

    typedef enum logic [1:0] {
        RS_PC4 = 2'b00,
        RS_ALU = 2'b01,
        RS_MEM = 2'b10,
        RS_IMM = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_pipelined_load_extend.sv
// Sub-word load extraction: picks the byte/halfword/word addressed by addr_lsb
// out of the aligned memory word and sign- or zero-extends it to XLEN.
module load_extend
    import riscv_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LSB_W = $clog2(XLEN/8)
) (
    input  logic [2:0]       funct3,
    input  logic [LSB_W-1:0] addr_lsb,
    input  logic [XLEN-1:0]  rdata,
    output logic [XLEN-1:0]  ext_data
);

    logic [7:0]      byte_lane [XLEN/8];
    logic [15:0]     half_lane [XLEN/16];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] lw_val;
    logic [XLEN-1:0] lwu_val;
    logic [XLEN-1:0] ld_val;

    genvar gi;
    generate
        for (gi = 0; gi < XLEN/8; gi++) begin : g_byte
            assign byte_lane[gi] = rdata[gi*8 +: 8];
        end
        for (gi = 0; gi < XLEN/16; gi++) begin : g_half
            assign half_lane[gi] = rdata[gi*16 +: 16];
        end

        if (XLEN == 64) begin : g_rv64
            logic [31:0] word_lane [2];
            logic [31:0] word_sel;
            for (gi = 0; gi < 2; gi++) begin : g_word
                assign word_lane[gi] = rdata[gi*32 +: 32];
            end
            assign word_sel = word_lane[addr_lsb[LSB_W-1]];
            assign lw_val   = {{32{word_sel[31]}}, word_sel};
            assign lwu_val  = {32'd0, word_sel};
            assign ld_val   = rdata;
        end else begin : g_rv32
            // LWU and LD are not defined at XLEN=32, so they fall back to the raw word.
            assign lw_val  = rdata;
            assign lwu_val = rdata;
            assign ld_val  = rdata;
        end
    endgenerate

    assign byte_sel = byte_lane[addr_lsb];
    assign half_sel = half_lane[addr_lsb[LSB_W-1:1]];

    always_comb begin
        ext_data = rdata;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   ext_data = lw_val;
            F3_LWU:  ext_data = lwu_val;
            F3_LD:   ext_data = ld_val;
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage: captures one MEM/WB entry, waits for load data
// when needed, and presents a single register-file write per entry.
module wb_stage_pipelined
    import riscv_wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LSB_W = $clog2(XLEN/8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc_plus4,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_result_src,
    input  logic [2:0]       in_funct3,
    input  logic [LSB_W-1:0] in_addr_lsb,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             flush,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             load_pending,
    output logic [4:0]       pending_rd
);

    wb_state_e         state_reg, state_next;
    logic [XLEN-1:0]   pc4_reg;
    logic [XLEN-1:0]   alu_reg;
    logic [XLEN-1:0]   imm_reg;
    logic [XLEN-1:0]   mem_data_reg;
    logic [4:0]        rd_reg;
    logic              reg_write_reg;
    result_src_e       src_reg;
    logic [2:0]        funct3_reg;
    logic [LSB_W-1:0]  lsb_reg;
    logic              capture;
    logic              latch_mem;
    logic [XLEN-1:0]   ext_data;

    assign in_ready  = (state_reg == IDLE) || (state_reg == WRITE);
    assign capture   = in_valid && in_ready && !flush;
    // Flush wins over a same-cycle response, so the response is simply dropped.
    assign latch_mem = (state_reg == WAIT_MEM) && mem_rvalid && !flush;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, WRITE: begin
                if (capture)
                    state_next = (result_src_e'(in_result_src) == RS_MEM) ? WAIT_MEM : WRITE;
                else
                    state_next = IDLE;
            end
            WAIT_MEM: begin
                if (flush)
                    state_next = IDLE;
                else if (mem_rvalid)
                    state_next = WRITE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            pc4_reg       <= '0;
            alu_reg       <= '0;
            imm_reg       <= '0;
            mem_data_reg  <= '0;
            rd_reg        <= '0;
            reg_write_reg <= 1'b0;
            src_reg       <= RS_PC4;
            funct3_reg    <= '0;
            lsb_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                pc4_reg       <= in_pc_plus4;
                alu_reg       <= in_alu_result;
                imm_reg       <= in_imm;
                rd_reg        <= in_rd;
                reg_write_reg <= in_reg_write;
                src_reg       <= result_src_e'(in_result_src);
                funct3_reg    <= in_funct3;
                lsb_reg       <= in_addr_lsb;
            end
            if (latch_mem)
                mem_data_reg <= mem_rdata;
        end
    end

    load_extend #(
        .XLEN  (XLEN),
        .LSB_W (LSB_W)
    ) u_load_extend (
        .funct3   (funct3_reg),
        .addr_lsb (lsb_reg),
        .rdata    (mem_data_reg),
        .ext_data (ext_data)
    );

    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        load_pending = 1'b0;
        pending_rd   = '0;
        if (state_reg == WRITE) begin
            rf_we    = reg_write_reg && (rd_reg != 5'd0);
            rf_waddr = rd_reg;
            case (src_reg)
                RS_PC4:  rf_wdata = pc4_reg;
                RS_ALU:  rf_wdata = alu_reg;
                RS_MEM:  rf_wdata = ext_data;
                RS_IMM:  rf_wdata = imm_reg;
                default: rf_wdata = '0;
            endcase
        end
        if (state_reg == WAIT_MEM) begin
            load_pending = 1'b1;
            pending_rd   = rd_reg;
        end
    end

endmodule
